sobel_magnitude_unit: RTL and testbench

Downstream stage of the Sobel gradient blocks (gx/gy window 1 and window 2). It takes the four signed gradients for one 3x4 pixel group, which is two adjacent 3x3 windows. For each window it computes the magnitude |gx|+|gy|, saturates it to 8 bits and optionally thresholds it to a binary edge pixel. It emits two output pixels per accepted group through a valid/ready handshake and counts edge pixels for the frame controller.

---
 rtl/sobel_pkg.sv | 14 +
 rtl/sobel_mag_lane.sv | 49 ++++
 rtl/sobel_magnitude_unit.sv | 131 +++++++++++++
 tb/tb_sobel_magnitude_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel magnitude stage.
// Holds the default widths, the gradient/pixel types and the pixel full-scale value.
package sobel_pkg;

  localparam int GRAD_W = 11;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 16;

  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic        [PIX_W-1:0]  pix_t;

  localparam pix_t PIX_MAX = pix_t'(255);

endpackage

// File: rtl/sobel_mag_lane.sv
// Combinational datapath for one 3x3 window.
// Ports:
//   gx, gy      signed gradients in; sum = |gx|+|gy| out (feeds the S1 register)
//   sum_q       registered sum from S1
//   thresh_en   1 = binary edge output, 0 = saturated magnitude
//   threshold   edge threshold, compared with >=
//   pixel       saturated/thresholded result (feeds the S2 register)
//   is_edge     pixel is full scale while thresholding is enabled
module sobel_mag_lane
  import sobel_pkg::*;
#(
  parameter int GRAD_W = sobel_pkg::GRAD_W,
  parameter int PIX_W  = sobel_pkg::PIX_W
) (
  input  logic signed [GRAD_W-1:0] gx,
  input  logic signed [GRAD_W-1:0] gy,
  output logic        [GRAD_W:0]   sum,
  input  logic        [GRAD_W:0]   sum_q,
  input  logic                     thresh_en,
  input  logic        [PIX_W-1:0]  threshold,
  output logic        [PIX_W-1:0]  pixel,
  output logic                     is_edge
);

  localparam logic [GRAD_W:0] MAG_MAX = (GRAD_W+1)'((2**PIX_W) - 1);

  logic [GRAD_W-1:0] abs_x;
  logic [GRAD_W-1:0] abs_y;
  logic [PIX_W-1:0]  mag;

  // Two's complement negate kept at GRAD_W bits unsigned: the most negative
  // input maps onto its own bit pattern, which read unsigned is the right magnitude.
  always_comb begin
    abs_x = gx[GRAD_W-1] ? (~gx + GRAD_W'(1)) : gx;
    abs_y = gy[GRAD_W-1] ? (~gy + GRAD_W'(1)) : gy;
    sum   = {1'b0, abs_x} + {1'b0, abs_y};
  end

  always_comb begin
    mag = (sum_q > MAG_MAX) ? '1 : sum_q[PIX_W-1:0];
    if (thresh_en) begin
      pixel = (mag >= threshold) ? '1 : '0;
    end else begin
      pixel = mag;
    end
    is_edge = thresh_en && (pixel == '1);
  end

endmodule

// File: rtl/sobel_magnitude_unit.sv
// Two-stage Sobel magnitude pipeline for a pair of adjacent 3x3 windows.
// S1 registers |gx|+|gy| per window, S2 registers the saturated or thresholded
// pixels and drives the output handshake. Edge pixels are counted per output
// handshake with a saturating counter.
// Ports:
//   clk, n_rst                 clock, async active-low reset
//   gx/gy_out_1, gx/gy_out_2   signed gradients for windows 1 and 2
//   grad_valid / grad_ready    input handshake (one group per transfer)
//   thresh_en, threshold       output mode, sampled when S2 loads
//   clear_count                synchronous clear of edge_count
//   pixel_out_1/2, out_valid   output pair, consumed when out_ready is high
//   edge_count                 edge pixels emitted since the last clear
module sobel_magnitude_unit
  import sobel_pkg::*;
#(
  parameter int GRAD_W = sobel_pkg::GRAD_W,
  parameter int PIX_W  = sobel_pkg::PIX_W,
  parameter int CNT_W  = sobel_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic signed [GRAD_W-1:0] gx_out_1,
  input  logic signed [GRAD_W-1:0] gy_out_1,
  input  logic signed [GRAD_W-1:0] gx_out_2,
  input  logic signed [GRAD_W-1:0] gy_out_2,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  input  logic                     thresh_en,
  input  logic        [PIX_W-1:0]  threshold,
  input  logic                     clear_count,
  output logic        [PIX_W-1:0]  pixel_out_1,
  output logic        [PIX_W-1:0]  pixel_out_2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [CNT_W-1:0]  edge_count
);

  logic              advance;
  logic              handshake;
  logic              s1_valid;
  logic [GRAD_W:0]   sum_1;
  logic [GRAD_W:0]   sum_2;
  logic [GRAD_W:0]   sum_1_q;
  logic [GRAD_W:0]   sum_2_q;
  logic [PIX_W-1:0]  pixel_1;
  logic [PIX_W-1:0]  pixel_2;
  logic              is_edge_1;
  logic              is_edge_2;
  logic              edge_1_q;
  logic              edge_2_q;
  logic [1:0]        pair_edges;
  logic [CNT_W:0]    count_sum;
  logic [CNT_W-1:0]  count_next;

  sobel_mag_lane #(.GRAD_W(GRAD_W), .PIX_W(PIX_W)) u_lane_1 (
    .gx        (gx_out_1),
    .gy        (gy_out_1),
    .sum       (sum_1),
    .sum_q     (sum_1_q),
    .thresh_en (thresh_en),
    .threshold (threshold),
    .pixel     (pixel_1),
    .is_edge   (is_edge_1)
  );

  sobel_mag_lane #(.GRAD_W(GRAD_W), .PIX_W(PIX_W)) u_lane_2 (
    .gx        (gx_out_2),
    .gy        (gy_out_2),
    .sum       (sum_2),
    .sum_q     (sum_2_q),
    .thresh_en (thresh_en),
    .threshold (threshold),
    .pixel     (pixel_2),
    .is_edge   (is_edge_2)
  );

  // The whole pipeline moves together; a stalled output freezes both stages.
  assign advance    = !out_valid || out_ready;
  assign grad_ready = advance;
  assign handshake  = out_valid && out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      sum_1_q  <= '0;
      sum_2_q  <= '0;
    end else if (advance) begin
      s1_valid <= grad_valid;
      if (grad_valid) begin
        sum_1_q <= sum_1;
        sum_2_q <= sum_2;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid   <= 1'b0;
      pixel_out_1 <= '0;
      pixel_out_2 <= '0;
      edge_1_q    <= 1'b0;
      edge_2_q    <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        pixel_out_1 <= pixel_1;
        pixel_out_2 <= pixel_2;
        edge_1_q    <= is_edge_1;
        edge_2_q    <= is_edge_2;
      end
    end
  end

  always_comb begin
    pair_edges = handshake ? ({1'b0, edge_1_q} + {1'b0, edge_2_q}) : 2'd0;
    count_sum  = {1'b0, edge_count} + (CNT_W+1)'(pair_edges);
    count_next = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
  end

  // A clear coinciding with a handshake still credits the pair being consumed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      edge_count <= '0;
    end else if (clear_count) begin
      edge_count <= CNT_W'(pair_edges);
    end else begin
      edge_count <= count_next;
    end
  end

endmodule

// File: tb/tb_sobel_magnitude_unit.sv
module tb_sobel_magnitude_unit;

  localparam int GRAD_W = 11;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                     clk;
  logic                     n_rst;
  logic signed [GRAD_W-1:0] gx_out_1, gy_out_1, gx_out_2, gy_out_2;
  logic                     grad_valid;
  logic                     grad_ready;
  logic                     thresh_en;
  logic        [PIX_W-1:0]  threshold;
  logic                     clear_count;
  logic        [PIX_W-1:0]  pixel_out_1, pixel_out_2;
  logic                     out_valid;
  logic                     out_ready;
  logic        [CNT_W-1:0]  edge_count;

  sobel_magnitude_unit #(.GRAD_W(GRAD_W), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .gx_out_1    (gx_out_1),
    .gy_out_1    (gy_out_1),
    .gx_out_2    (gx_out_2),
    .gy_out_2    (gy_out_2),
    .grad_valid  (grad_valid),
    .grad_ready  (grad_ready),
    .thresh_en   (thresh_en),
    .threshold   (threshold),
    .clear_count (clear_count),
    .pixel_out_1 (pixel_out_1),
    .pixel_out_2 (pixel_out_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .edge_count  (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p1;
    int p2;
    int edges;
  } pair_t;

  pair_t q[$];
  int    vec    = 0;
  int    mis    = 0;
  int    mcount = 0;

  function automatic int model_pix(int gx, int gy, bit ten, int thr);
    int s;
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (s > 255) s = 255;
    if (ten) return (s >= thr) ? 255 : 0;
    return s;
  endfunction

  // Reference model: groups queue up on accept, leave in order on each output
  // handshake; the edge counter follows the handshakes with saturation.
  initial begin : monitor
    bit    prev_stall;
    int    prev_p1, prev_p2;
    bit    hs;
    int    contrib;
    pair_t e;
    prev_stall = 0;
    prev_p1 = 0;
    prev_p2 = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!n_rst) begin
        q.delete();
        mcount = 0;
        prev_stall = 0;
      end else begin
        vec++;
        if (int'(edge_count) != mcount) begin
          mis++;
          $display("FAIL edge_count: got %0d expected %0d at %0t", edge_count, mcount, $time);
        end
        vec++;
        if (grad_ready !== (!out_valid || out_ready)) begin
          mis++;
          $display("FAIL grad_ready: got %0b expected %0b at %0t", grad_ready, !out_valid || out_ready, $time);
        end
        if (prev_stall) begin
          vec++;
          if (out_valid !== 1'b1 || int'(pixel_out_1) != prev_p1 || int'(pixel_out_2) != prev_p2) begin
            mis++;
            $display("FAIL stall_hold: got v=%0b %0d/%0d expected v=1 %0d/%0d at %0t",
                     out_valid, pixel_out_1, pixel_out_2, prev_p1, prev_p2, $time);
          end
        end
        hs = 0;
        if (out_valid) begin
          vec++;
          if (q.size() == 0) begin
            mis++;
            $display("FAIL spurious_out: got out_valid=1 expected no pending pair at %0t", $time);
          end else begin
            hs = out_ready;
            if (int'(pixel_out_1) != q[0].p1 || int'(pixel_out_2) != q[0].p2) begin
              mis++;
              $display("FAIL pixel_pair: got %0d/%0d expected %0d/%0d at %0t",
                       pixel_out_1, pixel_out_2, q[0].p1, q[0].p2, $time);
            end
          end
        end
        contrib = hs ? q[0].edges : 0;
        if (clear_count) mcount = contrib;
        else mcount = (mcount + contrib > CMAX) ? CMAX : mcount + contrib;
        if (hs) void'(q.pop_front());
        prev_stall = out_valid && !out_ready;
        prev_p1 = int'(pixel_out_1);
        prev_p2 = int'(pixel_out_2);
        if (grad_valid && grad_ready) begin
          e.p1 = model_pix(int'(gx_out_1), int'(gy_out_1), thresh_en, int'(threshold));
          e.p2 = model_pix(int'(gx_out_2), int'(gy_out_2), thresh_en, int'(threshold));
          e.edges = ((thresh_en && e.p1 == 255) ? 1 : 0) + ((thresh_en && e.p2 == 255) ? 1 : 0);
          q.push_back(e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one group and returns at posedge+1 after the edge that accepted it.
  task automatic send(input int a1x, input int a1y, input int a2x, input int a2y);
    bit acc;
    gx_out_1 = GRAD_W'(a1x);
    gy_out_1 = GRAD_W'(a1y);
    gx_out_2 = GRAD_W'(a2x);
    gy_out_2 = GRAD_W'(a2y);
    grad_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = grad_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = out_valid;
    end
    if (!seen) chk(name, 0, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    n_rst = 1'b0;
    gx_out_1 = '0; gy_out_1 = '0; gx_out_2 = '0; gy_out_2 = '0;
    grad_valid = 1'b0;
    thresh_en = 1'b0;
    threshold = '0;
    clear_count = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pixel_1", int'(pixel_out_1), 0);
    chk("rst_edge_count", int'(edge_count), 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
    chk("rst_grad_ready", int'(grad_ready), 1);

    // 1: latency and single-cycle output
    send(0, 0, 0, 400);
    grad_valid = 1'b0;
    @(negedge clk); #1;
    chk("t1_not_early", int'(out_valid), 0);
    @(negedge clk); #1;
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_pix1", int'(pixel_out_1), 0);
    chk("t1_pix2_sat", int'(pixel_out_2), 255);
    chk("t1_count", int'(edge_count), 0);
    @(negedge clk); #1;
    chk("t1_one_cycle", int'(out_valid), 0);

    // 2: sign handling and most-negative gradient
    send(-100, 50, -100, 50);
    send(-1024, -1024, -1024, -1024);
    grad_valid = 1'b0;
    wait_valid("t2_timeout");
    chk("t2_pix1_150", int'(pixel_out_1), 150);
    chk("t2_pix2_150", int'(pixel_out_2), 150);
    @(negedge clk); #1;
    chk("t2_valid_b", int'(out_valid), 1);
    chk("t2_pix1_neg", int'(pixel_out_1), 255);
    chk("t2_pix2_neg", int'(pixel_out_2), 255);
    cycles(3);

    // 3: threshold boundary, >= compare
    thresh_en = 1'b1;
    threshold = 8'd128;
    send(-100, 28, 0, -127);
    grad_valid = 1'b0;
    wait_valid("t3_timeout");
    chk("t3_pix1_edge", int'(pixel_out_1), 255);
    chk("t3_pix2_noedge", int'(pixel_out_2), 0);
    @(negedge clk); #1;
    chk("t3_count", int'(edge_count), 1);
    cycles(2);

    // 4: back-to-back stream with a 3-cycle output stall
    thresh_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(i * 10 + 1, 0, 0, -(i * 10 + 2));
        grad_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clk);
          #1;
          seen = out_valid;
        end
        if (!seen) chk("t4_timeout", 0, 1);
        out_ready = 1'b0;
        @(negedge clk); #1;
        chk("t4_ready_low", int'(grad_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("t4_hold_pix1", int'(pixel_out_1), 1);
        chk("t4_hold_pix2", int'(pixel_out_2), 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    cycles(8);
    chk("t4_drained", q.size(), 0);

    // 5: counter saturation, then clear coinciding with a 2-edge handshake
    thresh_en = 1'b1;
    threshold = 8'd10;
    for (int i = 0; i < 8; i++) send(100, 0, 0, 100);
    grad_valid = 1'b0;
    cycles(6);
    chk("t5_saturated", int'(edge_count), 15);
    send(-50, 0, 0, 60);
    grad_valid = 1'b0;
    cycles(4);
    chk("t5_stays_max", int'(edge_count), 15);
    send(20, 20, 30, -30);
    grad_valid = 1'b0;
    wait_valid("t5_timeout");
    clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    chk("t5_clear_plus_pair", int'(edge_count), 2);
    cycles(2);

    // 6: asynchronous reset with two groups in flight
    send(100, 100, 5, 0);
    send(0, 7, 200, 0);
    grad_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6_valid_cleared", int'(out_valid), 0);
    chk("t6_pix1_cleared", int'(pixel_out_1), 0);
    chk("t6_pix2_cleared", int'(pixel_out_2), 0);
    chk("t6_count_cleared", int'(edge_count), 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
    chk("t6_ready_after", int'(grad_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("t6_no_stale", int'(out_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
